spi_ram_ctrl: RTL and testbench

Single-port synchronous RAM with a command decoder, placed directly downstream of the SPI slave. It takes each 10-bit word the slave delivers on `din`/`rx_valid`, splits it into a 2-bit command and an 8-bit payload, and performs one action per word: load the write address, write data, load the read address, or read data. For reads it returns the byte on `dout` with `tx_valid` held high, so the slave can shift it out on miso.

---
 rtl/spi_ram_ctrl_if.sv | 10 +
 rtl/spi_ram_ctrl.sv | 84 ++++++++
 tb/tb_spi_ram_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/spi_ram_ctrl_if.sv
// Word-level link between the SPI slave (master side) and the RAM controller (slave side).
interface spi_ram_ctrl_if;
    logic [9:0] din;
    logic       rx_valid;
    logic [7:0] dout;
    logic       tx_valid;

    modport master (output din, rx_valid, input  dout, tx_valid);
    modport slave  (input  din, rx_valid, output dout, tx_valid);
endinterface

// File: rtl/spi_ram_ctrl.sv
// Command-decoding single-port RAM behind the SPI slave: each rx_valid rise carries
// one 2-bit command plus 8-bit payload (set/write/read address pointers and data).
module spi_ram_ctrl #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int AUTO_INC  = 1
) (
    input  logic             clk,
    input  logic             rst,
    spi_ram_ctrl_if.slave    bus
);
    typedef enum logic [1:0] {
        CMD_WADDR = 2'b00,
        CMD_WDATA = 2'b01,
        CMD_RADDR = 2'b10,
        CMD_RDATA = 2'b11
    } cmd_e;

    logic [7:0]           mem [MEM_DEPTH];

    logic                 rx_valid_q;
    logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]           dout_q, dout_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 we;
    logic                 accept;
    cmd_e                 cmd;
    logic [7:0]           payload;

    assign accept  = bus.rx_valid & ~rx_valid_q;
    assign cmd     = cmd_e'(bus.din[9:8]);
    assign payload = bus.din[7:0];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        dout_d     = dout_q;
        tx_valid_d = tx_valid_q;
        we         = 1'b0;
        if (accept) begin
            // Any accepted word other than a read ends the current tx byte.
            tx_valid_d = 1'b0;
            unique case (cmd)
                CMD_WADDR: wr_ptr_d = ADDR_SIZE'(payload);
                CMD_WDATA: begin
                    we = 1'b1;
                    if (AUTO_INC != 0) wr_ptr_d = wr_ptr_q + ADDR_SIZE'(1);
                end
                CMD_RADDR: rd_ptr_d = ADDR_SIZE'(payload);
                CMD_RDATA: begin
                    dout_d     = mem[rd_ptr_q];
                    tx_valid_d = 1'b1;
                    if (AUTO_INC != 0) rd_ptr_d = rd_ptr_q + ADDR_SIZE'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_valid_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            dout_q     <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= bus.rx_valid;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            dout_q     <= dout_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    // Array is not reset so contents survive rst; a write arriving during rst is dropped.
    always_ff @(posedge clk) begin
        if (!rst && we) mem[wr_ptr_q] <= payload;
    end

    assign bus.dout     = dout_q;
    assign bus.tx_valid = tx_valid_q;
endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl: command sequences with hand-computed read-back values.
module tb_spi_ram_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;

    spi_ram_ctrl_if bus ();

    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise rx_valid with a word; returns just after the accepting edge.
    task automatic rise(input logic [9:0] w);
        bus.din      = w;
        bus.rx_valid = 1'b1;
        tick();
    endtask

    // Keep the level high for extra cycles, then drop it for one gap cycle.
    task automatic fall(input int extra_high);
        repeat (extra_high) tick();
        bus.rx_valid = 1'b0;
        tick();
    endtask

    task automatic send(input logic [9:0] w);
        rise(w);
        fall(2);
    endtask

    initial begin
        rst          = 1'b1;
        bus.din      = '0;
        bus.rx_valid = 1'b0;
        repeat (3) tick();
        chk("rst_dout",  {24'b0, bus.dout}, 32'h00);
        chk("rst_txv",   {31'b0, bus.tx_valid}, 32'h0);
        chk("rst_wrptr", {24'b0, dut.wr_ptr_q}, 32'h00);
        chk("rst_rdptr", {24'b0, dut.rd_ptr_q}, 32'h00);
        rst = 1'b0;
        tick();

        // Basic write then read back
        send(10'h012);
        chk("basic_txv0_a", {31'b0, bus.tx_valid}, 32'h0);
        send(10'h1A5);
        chk("basic_txv0_b", {31'b0, bus.tx_valid}, 32'h0);
        send(10'h212);
        chk("basic_txv0_c", {31'b0, bus.tx_valid}, 32'h0);
        rise(10'h300);
        chk("basic_dout",  {24'b0, bus.dout}, 32'hA5);
        chk("basic_txv1",  {31'b0, bus.tx_valid}, 32'h1);
        fall(2);
        chk("basic_rdptr", {24'b0, dut.rd_ptr_q}, 32'h13);

        // Auto-increment on both pointers
        send(10'h010);
        send(10'h111);
        send(10'h122);
        send(10'h210);
        rise(10'h300);
        chk("ainc_rd0", {24'b0, bus.dout}, 32'h11);
        fall(2);
        rise(10'h300);
        chk("ainc_rd1", {24'b0, bus.dout}, 32'h22);
        fall(2);
        chk("ainc_rdptr", {24'b0, dut.rd_ptr_q}, 32'h12);

        // Pointer wrap from 0xFF to 0x00
        send(10'h0FF);
        send(10'h1AA);
        send(10'h1BB);
        chk("wrap_wrptr", {24'b0, dut.wr_ptr_q}, 32'h01);
        send(10'h2FF);
        rise(10'h300);
        chk("wrap_rd0", {24'b0, bus.dout}, 32'hAA);
        fall(2);
        rise(10'h300);
        chk("wrap_rd1", {24'b0, bus.dout}, 32'hBB);
        fall(2);
        chk("wrap_rdptr", {24'b0, dut.rd_ptr_q}, 32'h01);

        // Level-held rx_valid gives exactly one write
        send(10'h006);
        send(10'h1C3);
        send(10'h005);
        rise(10'h177);
        fall(19);
        chk("hold_wrptr", {24'b0, dut.wr_ptr_q}, 32'h06);
        send(10'h205);
        rise(10'h300);
        chk("hold_mem05", {24'b0, bus.dout}, 32'h77);
        fall(2);
        rise(10'h300);
        chk("hold_mem06", {24'b0, bus.dout}, 32'hC3);
        fall(2);

        // Non-read word clears tx_valid but leaves dout alone
        chk("life_txv_pre", {31'b0, bus.tx_valid}, 32'h1);
        rise(10'h240);
        chk("life_txv0", {31'b0, bus.tx_valid}, 32'h0);
        chk("life_dout", {24'b0, bus.dout}, 32'hC3);
        fall(2);
        chk("life_rdptr", {24'b0, dut.rd_ptr_q}, 32'h40);

        // Reset in the middle of operation keeps RAM contents
        send(10'h032);
        send(10'h14D);
        send(10'h15A);
        send(10'h232);
        rise(10'h300);
        chk("mid_dout_pre", {24'b0, bus.dout}, 32'h4D);
        fall(2);
        chk("mid_rdptr_pre", {24'b0, dut.rd_ptr_q}, 32'h33);
        chk("mid_txv_pre",   {31'b0, bus.tx_valid}, 32'h1);
        rst = 1'b1;
        tick();
        chk("mid_txv",   {31'b0, bus.tx_valid}, 32'h0);
        chk("mid_dout",  {24'b0, bus.dout}, 32'h00);
        chk("mid_wrptr", {24'b0, dut.wr_ptr_q}, 32'h00);
        chk("mid_rdptr", {24'b0, dut.rd_ptr_q}, 32'h00);
        rst = 1'b0;
        tick();
        send(10'h233);
        rise(10'h300);
        chk("mid_mem33", {24'b0, bus.dout}, 32'h5A);
        chk("mid_txv1",  {31'b0, bus.tx_valid}, 32'h1);
        fall(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
